cond_exec_ctrl: RTL and testbench

COND_EXEC_CTRL -- requirements
Module: cond_exec_ctrl

---
 rtl/cond_exec_ctrl.sv | 119 +++++++++++
 tb/tb_cond_exec_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cond_exec_ctrl.sv
// ARM-style conditional-execution controller: evaluates the condition field
// against the status flags, commits or skips, and sequences the post-branch flush.
module cond_exec_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [3:0]       cond,
    input  logic             s_bit,
    input  logic             is_branch,
    input  logic [3:0]       alu_nzcv,
    input  logic             stall,
    output logic [3:0]       nzcv,
    output logic             exec_en,
    output logic             branch_taken,
    output logic             flush,
    output logic             undef_cond,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;
    localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
    logic             pass;
    logic             flag_n, flag_z, flag_c, flag_v;

    assign {flag_n, flag_z, flag_c, flag_v} = nzcv_q;

    always_comb begin
        pass = 1'b0;
        case (cond)
            4'b0000: pass = flag_z;
            4'b0001: pass = !flag_z;
            4'b0010: pass = flag_c;
            4'b0011: pass = !flag_c;
            4'b0100: pass = flag_n;
            4'b0101: pass = !flag_n;
            4'b0110: pass = flag_v;
            4'b0111: pass = !flag_v;
            4'b1000: pass = flag_c && !flag_z;
            4'b1001: pass = !flag_c || flag_z;
            4'b1010: pass = (flag_n == flag_v);
            4'b1011: pass = (flag_n != flag_v);
            4'b1100: pass = !flag_z && (flag_n == flag_v);
            4'b1101: pass = flag_z || (flag_n != flag_v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    assign exec_en      = (state_q == RUN) && instr_valid && pass && !stall;
    assign branch_taken = exec_en && is_branch;
    assign flush        = (state_q == FLUSH);
    assign undef_cond   = instr_valid && (cond == 4'b1111) && (state_q == RUN);

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        nzcv_d     = nzcv_q;
        exec_cnt_d = exec_cnt_q;
        skip_cnt_d = skip_cnt_q;

        if (exec_en && s_bit)
            nzcv_d = alu_nzcv;

        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    state_d = FLUSH;
                    fcnt_d  = FCNT_INIT;
                end
            end
            default: begin
                if (!stall) begin
                    if (fcnt_q == 3'd0)
                        state_d = RUN;
                    else
                        fcnt_d = fcnt_q - 3'd1;
                end
            end
        endcase

        // Counters saturate at all-ones rather than wrapping.
        if (exec_en && (exec_cnt_q != '1))
            exec_cnt_d = exec_cnt_q + 1'b1;
        if (instr_valid && !stall && !exec_en && (skip_cnt_q != '1))
            skip_cnt_d = skip_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            fcnt_q     <= '0;
            nzcv_q     <= '0;
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            nzcv_q     <= nzcv_d;
            exec_cnt_q <= exec_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign nzcv     = nzcv_q;
    assign exec_cnt = exec_cnt_q;
    assign skip_cnt = skip_cnt_q;

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Directed bench for cond_exec_ctrl; expected values are hand-computed per step.
module tb_cond_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [3:0]  cond;
    logic        s_bit;
    logic        is_branch;
    logic [3:0]  alu_nzcv;
    logic        stall;
    logic [3:0]  nzcv;
    logic        exec_en;
    logic        branch_taken;
    logic        flush;
    logic        undef_cond;
    logic [15:0] exec_cnt;
    logic [15:0] skip_cnt;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    localparam logic [3:0] EQ = 4'b0000, NE = 4'b0001, LS = 4'b1001,
                           GT = 4'b1100, AL = 4'b1110, NV = 4'b1111;

    cond_exec_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .cond(cond),
        .s_bit(s_bit), .is_branch(is_branch), .alu_nzcv(alu_nzcv), .stall(stall),
        .nzcv(nzcv), .exec_en(exec_en), .branch_taken(branch_taken), .flush(flush),
        .undef_cond(undef_cond), .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic s,
                         input logic br, input logic [3:0] alu, input logic st);
        instr_valid = v; cond = c; s_bit = s; is_branch = br; alu_nzcv = alu; stall = st;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, AL, 1'b0, 1'b0, 4'h0, 1'b0);
        #1;
        check("rst_nzcv", 32'(nzcv), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_exec_cnt", 32'(exec_cnt), 32'h0);
        check("rst_skip_cnt", 32'(skip_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // EQ with Z=0 fails, then AL executes
        drive(1'b1, EQ, 1'b0, 1'b0, 4'h0, 1'b0);
        check("eq_z0_exec_en", 32'(exec_en), 32'h0);
        check("eq_undef", 32'(undef_cond), 32'h0);
        tick();
        check("eq_skip_cnt", 32'(skip_cnt), 32'h1);
        check("eq_exec_cnt", 32'(exec_cnt), 32'h0);
        drive(1'b1, AL, 1'b0, 1'b0, 4'h0, 1'b0);
        check("al_exec_en", 32'(exec_en), 32'h1);
        check("al_branch", 32'(branch_taken), 32'h0);
        tick();
        check("al_exec_cnt", 32'(exec_cnt), 32'h1);

        // Flag write, visible to the next instruction
        drive(1'b1, AL, 1'b1, 1'b0, 4'b0100, 1'b0);
        tick();
        check("sbit_nzcv", 32'(nzcv), 32'h4);
        check("sbit_exec_cnt", 32'(exec_cnt), 32'h2);
        drive(1'b1, EQ, 1'b0, 1'b0, 4'h0, 1'b0);
        check("eq_z1_exec_en", 32'(exec_en), 32'h1);
        drive(1'b1, NE, 1'b0, 1'b0, 4'h0, 1'b0);
        check("ne_z1_exec_en", 32'(exec_en), 32'h0);
        drive(1'b1, LS, 1'b0, 1'b0, 4'h0, 1'b0);
        check("ls_z1_exec_en", 32'(exec_en), 32'h1);
        drive(1'b1, GT, 1'b0, 1'b0, 4'h0, 1'b0);
        check("gt_z1_exec_en", 32'(exec_en), 32'h0);
        tick();
        check("gt_skip_cnt", 32'(skip_cnt), 32'h2);

        // Taken branch, 2-cycle flush
        drive(1'b1, AL, 1'b0, 1'b1, 4'h0, 1'b0);
        check("br_taken", 32'(branch_taken), 32'h1);
        check("br_flush_pre", 32'(flush), 32'h0);
        tick();
        check("br_exec_cnt", 32'(exec_cnt), 32'h3);
        check("fl1_flush", 32'(flush), 32'h1);
        check("fl1_exec_en", 32'(exec_en), 32'h0);
        check("fl1_branch", 32'(branch_taken), 32'h0);
        tick();
        check("fl2_flush", 32'(flush), 32'h1);
        check("fl2_exec_en", 32'(exec_en), 32'h0);
        check("fl1_skip_cnt", 32'(skip_cnt), 32'h3);
        drive(1'b1, AL, 1'b0, 1'b0, 4'h0, 1'b0);
        tick();
        check("fl_end_flush", 32'(flush), 32'h0);
        check("fl_skip_cnt", 32'(skip_cnt), 32'h4);
        check("fl_end_exec_en", 32'(exec_en), 32'h1);
        tick();
        check("post_fl_exec_cnt", 32'(exec_cnt), 32'h4);

        // Branch with a 3-cycle stall inside the flush
        drive(1'b1, AL, 1'b0, 1'b1, 4'h0, 1'b0);
        tick();
        check("st_fl1_flush", 32'(flush), 32'h1);
        check("st_exec_cnt", 32'(exec_cnt), 32'h5);
        drive(1'b1, AL, 1'b0, 1'b0, 4'h0, 1'b0);
        tick();
        check("st_fl1_skip", 32'(skip_cnt), 32'h5);
        drive(1'b1, AL, 1'b1, 1'b0, 4'hF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("st_flush", 32'(flush), 32'h1);
            check("st_exec_en", 32'(exec_en), 32'h0);
            tick();
            check("st_skip_hold", 32'(skip_cnt), 32'h5);
            check("st_exec_hold", 32'(exec_cnt), 32'h5);
            check("st_nzcv_hold", 32'(nzcv), 32'h4);
        end
        drive(1'b1, AL, 1'b0, 1'b0, 4'h0, 1'b0);
        check("st_last_flush", 32'(flush), 32'h1);
        tick();
        check("st_end_flush", 32'(flush), 32'h0);
        check("st_end_skip", 32'(skip_cnt), 32'h6);

        // Undefined condition
        drive(1'b1, NV, 1'b0, 1'b0, 4'h0, 1'b0);
        check("nv_undef", 32'(undef_cond), 32'h1);
        check("nv_exec_en", 32'(exec_en), 32'h0);
        tick();
        check("nv_skip_cnt", 32'(skip_cnt), 32'h7);

        // Reset pulsed between edges while flushing
        drive(1'b1, AL, 1'b1, 1'b1, 4'b1000, 1'b0);
        tick();
        check("rf_nzcv", 32'(nzcv), 32'h8);
        check("rf_flush", 32'(flush), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("rf_rst_flush", 32'(flush), 32'h0);
        check("rf_rst_nzcv", 32'(nzcv), 32'h0);
        check("rf_rst_exec_cnt", 32'(exec_cnt), 32'h0);
        check("rf_rst_skip_cnt", 32'(skip_cnt), 32'h0);
        #1 rst = 1'b0;
        drive(1'b1, AL, 1'b0, 1'b0, 4'h0, 1'b0);
        check("rf_after_exec_en", 32'(exec_en), 32'h1);
        tick();
        check("rf_after_exec_cnt", 32'(exec_cnt), 32'h1);
        check("rf_after_flush", 32'(flush), 32'h0);

        // Saturation of exec_cnt
        repeat (65533) tick();
        check("sat_near", 32'(exec_cnt), 32'hFFFE);
        tick();
        check("sat_reach", 32'(exec_cnt), 32'hFFFF);
        repeat (3) tick();
        check("sat_hold", 32'(exec_cnt), 32'hFFFF);
        check("sat_skip_cnt", 32'(skip_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
